// File: rtl/amplitude_ram_responder.sv
// Responder for the stabilizer amplitude-RAM handshake: owns RAM ALPHA and RAM AMP2 and
// builds AMP2 = ALPHA / sqrt2 (masked by match_vector). Optional macro: AMP2_ZERO_COUNT_EN.
module amplitude_ram_responder #(
   parameter int unsigned num_qubit = 4,
   parameter int unsigned amp_width = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          determine_amplitude2,
   input  logic [(2**num_qubit)-1:0]     match_vector,
   input  logic                          read_ram_alpha_stabilizer_en,
   input  logic [num_qubit-1:0]          read_ram_alpha_stabilizer_address,
   output logic [2*amp_width-1:0]        read_ram_alpha_data,
   output logic                          read_ram_alpha_valid,
   input  logic                          write_amplitude_alpha_stabilizer_en,
   input  logic [num_qubit-1:0]          write_amplitude_alpha_stabilizer_address,
   input  logic [2*amp_width-1:0]        write_amplitude_alpha_data,
   input  logic                          read_amp2_en,
   input  logic [num_qubit-1:0]          read_amp2_address,
   output logic [2*amp_width-1:0]        read_amp2_data,
   output logic                          ram_amplitude_busy,
   output logic                          done_amplitude
`ifdef AMP2_ZERO_COUNT_EN
   ,
   output logic [num_qubit:0]            zero_count
`endif
);

   localparam int unsigned DEPTH = 2 ** num_qubit;
   localparam int unsigned DW    = 2 * amp_width;
   localparam int unsigned PW    = 2 * amp_width;

   // round(sqrt(x)) evaluated at elaboration; 1/sqrt2 in Q1.(amp_width-1) is round(sqrt(2**(2w-3)))
   function automatic longint unsigned isqrt_round(input longint unsigned x);
      longint unsigned r;
      longint unsigned t;
      r = 64'(0);
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'(1) << b);
         if (t * t <= x) r = t;
      end
      if (x - r * r > r) r = r + 64'(1);
      return r;
   endfunction

   localparam longint unsigned          SCALE_U = isqrt_round(64'(1) << (2 * amp_width - 3));
   localparam logic signed [amp_width-1:0] SCALE = amp_width'(SCALE_U);
   localparam logic signed [PW-1:0]     ROUND_C = PW'(1) << (amp_width - 2);

   // Multiply by 1/sqrt2 with round-half-up; magnitude never reaches full scale
   function automatic logic [amp_width-1:0] scale_comp(input logic signed [amp_width-1:0] v);
      logic signed [PW-1:0] prod;
      prod = PW'(v) * PW'(SCALE);
      prod = prod + ROUND_C;
      return amp_width'(prod >>> (amp_width - 1));
   endfunction

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [num_qubit-1:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0]       match_q;
   logic                   accept;
   logic                   sweep_rd;
   logic                   ext_rd;
   logic                   busy_d;
   logic                   done_d;

   logic [DW-1:0]          ram_alpha [DEPTH];
   logic [DW-1:0]          ram_amp2  [DEPTH];

   logic [DW-1:0]          sweep_data;
   logic                   s1_valid;
   logic [num_qubit-1:0]   s1_addr;
   logic                   s2_valid;
   logic [num_qubit-1:0]   s2_addr;
   logic [DW-1:0]          s2_data;
   logic                   s2_zero;

   // State register and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         match_q            <= '0;
         ram_amplitude_busy <= 1'b0;
         done_amplitude     <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         ram_amplitude_busy <= busy_d;
         done_amplitude     <= done_d;
         if (accept) match_q <= match_vector;
      end
   end

   // Next-state logic; the counter doubles as the drain cycle counter
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      sweep_rd = 1'b0;
      case (state_q)
         IDLE: begin
            if (determine_amplitude2) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            sweep_rd = 1'b1;
            if (cnt_q == num_qubit'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + num_qubit'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == num_qubit'(1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + num_qubit'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign ext_rd = read_ram_alpha_stabilizer_en && (state_q == IDLE);

   // RAM ALPHA write port, open in every state
   always_ff @(posedge clk) begin
      if (write_amplitude_alpha_stabilizer_en)
         ram_alpha[write_amplitude_alpha_stabilizer_address] <= write_amplitude_alpha_data;
   end

   // RAM ALPHA read ports: external (idle only) and sweep; both see pre-write data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_ram_alpha_data  <= '0;
         read_ram_alpha_valid <= 1'b0;
         sweep_data           <= '0;
      end else begin
         read_ram_alpha_valid <= ext_rd;
         if (ext_rd) read_ram_alpha_data <= ram_alpha[read_ram_alpha_stabilizer_address];
         if (sweep_rd) sweep_data <= ram_alpha[cnt_q];
      end
   end

   // Sweep pipeline: stage 1 scales and masks, stage 2 writes AMP2
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_data  <= '0;
         s2_zero  <= 1'b0;
      end else begin
         s1_valid <= sweep_rd;
         s1_addr  <= cnt_q;
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_zero  <= ~match_q[s1_addr];
         if (match_q[s1_addr])
            s2_data <= {scale_comp(sweep_data[DW-1:amp_width]), scale_comp(sweep_data[amp_width-1:0])};
         else
            s2_data <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (s2_valid) ram_amp2[s2_addr] <= s2_data;
   end

   // RAM AMP2 read port, one-cycle latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_amp2_data <= '0;
      end else if (read_amp2_en) begin
         read_amp2_data <= ram_amp2[read_amp2_address];
      end
   end

`ifdef AMP2_ZERO_COUNT_EN
   // Entries forced to zero by a mismatch during the most recent sweep
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zero_count <= '0;
      end else if (accept) begin
         zero_count <= '0;
      end else if (s2_valid && s2_zero) begin
         zero_count <= zero_count + (num_qubit + 1)'(1);
      end
   end
`endif

endmodule
